// File: rtl/led_pwm_bank.sv
// led_pwm_bank: N-channel LED PWM engine with an integrated register bank.
// Host access is a simple strobe-based register bus (addr/w_en/r_en).
// Each LED can be OFF, ON, individually dimmed, or group dimmed/blinked.
// Optional build macro LED_PWM_SHADOW_EN: PWMn, GRPPWM and GRPFREQ writes go
// to shadow copies that are applied on the PWM period wrap (glitch-free).
// Without the macro those writes take effect on the next clock.

module led_pwm_bank #(
    parameter int NUM_LEDS  = 4,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sleep,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 w_en,
    input  logic                 r_en,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rvalid,
    output logic [NUM_LEDS-1:0]  led_out
);

    localparam int DB           = DATA_BITS;
    localparam int GRPPWM_ADDR  = NUM_LEDS + 1;
    localparam int GRPFREQ_ADDR = NUM_LEDS + 2;
    localparam int LOUT_BASE    = NUM_LEDS + 3;
    localparam int NUM_LOUT     = (NUM_LEDS + 3) / 4;

    localparam logic [1:0] LED_OFF = 2'd0;
    localparam logic [1:0] LED_ON  = 2'd1;
    localparam logic [1:0] LED_IND = 2'd2;
    localparam logic [1:0] LED_GRP = 2'd3;

    localparam logic [DB:0] ONE_EXT = 1;

    genvar gi;

    // Address widened once so every decode compares against plain integers.
    logic [31:0] addr_w;
    assign addr_w = 32'(addr);

    // ------------------------------------------------------------------
    // MODE register and derived control bits
    // ------------------------------------------------------------------
    logic [DB-1:0] mode_reg;
    logic          asleep;
    logic          dim_blink;
    logic          invert;
    logic          output_change;

    // MODE is plain storage; auto_increment and reserved bits are kept for readback only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg <= '0;
        end else if (w_en && addr_w == 32'd0) begin
            mode_reg <= wdata;
        end
    end

    assign asleep        = sleep | mode_reg[4];
    assign dim_blink     = mode_reg[3];
    assign invert        = mode_reg[2];
    assign output_change = mode_reg[1];

    // ------------------------------------------------------------------
    // PWM period and blink counters
    // ------------------------------------------------------------------
    logic [DB-1:0] pwm_cnt_reg;
    logic [DB-1:0] blink_cnt_reg;
    logic          wrap;

    // wrap marks the last clock of a PWM period (the edge where pwm_cnt rolls to 0).
    assign wrap = !asleep && (pwm_cnt_reg == {DB{1'b1}});

    // Free-running period counter, parked at 0 while asleep so wake-up starts a fresh period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_reg <= '0;
        end else if (asleep) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + DB'(1);
        end
    end

    // ------------------------------------------------------------------
    // Group registers (host-visible copy and the copy the PWM logic uses)
    // ------------------------------------------------------------------
    logic [DB-1:0] grppwm_wr_reg;
    logic [DB-1:0] grpfreq_wr_reg;
    logic [DB-1:0] grppwm_act;
    logic [DB-1:0] grpfreq_act;

    // Host writes to GRPPWM / GRPFREQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grppwm_wr_reg  <= '1;
            grpfreq_wr_reg <= '0;
        end else if (w_en) begin
            if (addr_w == 32'(GRPPWM_ADDR)) begin
                grppwm_wr_reg <= wdata;
            end
            if (addr_w == 32'(GRPFREQ_ADDR)) begin
                grpfreq_wr_reg <= wdata;
            end
        end
    end

`ifdef LED_PWM_SHADOW_EN
    logic [DB-1:0] grppwm_act_reg;
    logic [DB-1:0] grpfreq_act_reg;

    // Shadowed group values are applied only at the period boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grppwm_act_reg  <= '1;
            grpfreq_act_reg <= '0;
        end else if (wrap) begin
            grppwm_act_reg  <= grppwm_wr_reg;
            grpfreq_act_reg <= grpfreq_wr_reg;
        end
    end

    assign grppwm_act  = grppwm_act_reg;
    assign grpfreq_act = grpfreq_act_reg;
`else
    assign grppwm_act  = grppwm_wr_reg;
    assign grpfreq_act = grpfreq_wr_reg;
`endif

    // Blink counter advances once per period and returns to 0 after reaching GRPFREQ.
    // The compare uses the written GRPFREQ: that is the value in force after this
    // wrap in either build, and '>=' also clears a count stranded above a lowered GRPFREQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_reg <= '0;
        end else if (asleep) begin
            blink_cnt_reg <= '0;
        end else if (wrap) begin
            if (blink_cnt_reg >= grpfreq_wr_reg) begin
                blink_cnt_reg <= '0;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + DB'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Group blink gate: blink_cnt * 2^DB < (GRPFREQ + 1) * GRPPWM, full width
    // ------------------------------------------------------------------
    logic [2*DB:0] blink_pos;
    logic [2*DB:0] blink_lim;
    logic          group_gate;

    assign blink_pos  = {1'b0, blink_cnt_reg, {DB{1'b0}}};
    assign blink_lim  = {{DB{1'b0}}, ({1'b0, grpfreq_act} + ONE_EXT)} *
                        {{(DB + 1){1'b0}}, grppwm_act};
    assign group_gate = !dim_blink || (blink_pos < blink_lim);

    // ------------------------------------------------------------------
    // Per-LED duty registers, mode registers and raw output
    // ------------------------------------------------------------------
    logic [DB*NUM_LEDS-1:0] pwm_rd_all;
    logic [2*NUM_LEDS-1:0]  lmode_rd_all;
    logic [NUM_LEDS-1:0]    raw;

    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            localparam int LOUT_ADDR = LOUT_BASE + gi / 4;
            localparam int LOUT_LSB  = 2 * (gi % 4);

            logic [DB-1:0]   pwm_wr_reg;
            logic [DB-1:0]   pwm_act;
            logic [1:0]      lmode_wr_reg;
            logic [1:0]      lmode_act_reg;
            logic [1:0]      lmode_eff;
            logic [2*DB-1:0] grp_prod;
            logic [2*DB-1:0] grp_duty;
            logic            ind_on;
            logic            raw_bit;

            // Host write to PWMn.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pwm_wr_reg <= '0;
                end else if (w_en && addr_w == 32'(gi + 1)) begin
                    pwm_wr_reg <= wdata;
                end
            end

`ifdef LED_PWM_SHADOW_EN
            logic [DB-1:0] pwm_act_reg;

            // Shadowed duty is applied at the period boundary.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pwm_act_reg <= '0;
                end else if (wrap) begin
                    pwm_act_reg <= pwm_wr_reg;
                end
            end

            assign pwm_act = pwm_act_reg;
`else
            assign pwm_act = pwm_wr_reg;
`endif

            // Host write to this LED's 2-bit field inside its LEDOUT register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lmode_wr_reg <= LED_OFF;
                end else if (w_en && addr_w == 32'(LOUT_ADDR)) begin
                    lmode_wr_reg <= wdata[LOUT_LSB +: 2];
                end
            end

            // Applied mode tracks the written one every clock in immediate mode,
            // otherwise only at the period boundary.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lmode_act_reg <= LED_OFF;
                end else if (output_change || wrap) begin
                    lmode_act_reg <= lmode_wr_reg;
                end
            end

            assign lmode_eff = output_change ? lmode_wr_reg : lmode_act_reg;

            // Group-dimmed duty is (PWMn * GRPPWM) >> DB, kept wide for the compare.
            assign grp_prod = {{DB{1'b0}}, pwm_act} * {{DB{1'b0}}, grppwm_act};
            assign grp_duty = grp_prod >> DB;
            assign ind_on   = pwm_cnt_reg < pwm_act;

            // Raw (pre-inversion) LED level from the selected mode.
            always_comb begin
                raw_bit = 1'b0;
                case (lmode_eff)
                    LED_OFF: raw_bit = 1'b0;
                    LED_ON:  raw_bit = 1'b1;
                    LED_IND: raw_bit = ind_on;
                    LED_GRP: begin
                        if (dim_blink) begin
                            raw_bit = ind_on && group_gate;
                        end else begin
                            raw_bit = {{DB{1'b0}}, pwm_cnt_reg} < grp_duty;
                        end
                    end
                    default: raw_bit = 1'b0;
                endcase
            end

            assign raw[gi]                   = raw_bit;
            assign pwm_rd_all[gi*DB +: DB]   = pwm_wr_reg;
            assign lmode_rd_all[2*gi +: 2]   = lmode_wr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [8*NUM_LOUT-1:0] lout_img;
    logic [DB-1:0]         rd_mux;
    logic [DB-1:0]         rdata_reg;
    logic                  rvalid_reg;
    logic [NUM_LEDS-1:0]   led_out_reg;

    // LEDOUT image padded with zeros for LED slots that do not exist.
    always_comb begin
        lout_img                   = '0;
        lout_img[2*NUM_LEDS-1:0]   = lmode_rd_all;
    end

    // Register read multiplexer; unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        if (addr_w == 32'd0) begin
            rd_mux = mode_reg;
        end else if (addr_w == 32'(GRPPWM_ADDR)) begin
            rd_mux = grppwm_wr_reg;
        end else if (addr_w == 32'(GRPFREQ_ADDR)) begin
            rd_mux = grpfreq_wr_reg;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr_w == 32'(i + 1)) begin
                    rd_mux = pwm_rd_all[i*DB +: DB];
                end
            end
            for (int k = 0; k < NUM_LOUT; k++) begin
                if (addr_w == 32'(LOUT_BASE + k)) begin
                    rd_mux[7:0] = lout_img[8*k +: 8];
                end
            end
        end
    end

    // Registered read response; sampling before any same-edge write gives pre-write data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= r_en;
            if (r_en) begin
                rdata_reg <= rd_mux;
            end
        end
    end

    // Output stage: one cycle behind pwm_cnt, forced to the idle level while asleep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_out_reg <= '0;
        end else if (asleep) begin
            led_out_reg <= {NUM_LEDS{invert}};
        end else begin
            led_out_reg <= raw ^ {NUM_LEDS{invert}};
        end
    end

    assign rdata   = rdata_reg;
    assign rvalid  = rvalid_reg;
    assign led_out = led_out_reg;

endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

N-channel LED PWM engine with an integrated register bank, the parametrised successor to the fixed 4-LED driver register map. The I2C controller accesses it through a simple register bus. It generates per-LED PWM, group dimming and group blinking, with optional double-buffered duty updates. It sits between the I2C controller and the LED pins, and honours the global sleep signal.

## Interface
- NUM_LEDS, 4: LED channel count, legal range 1..8.
- DATA_BITS, 8: register width; the PWM period is 2^DATA_BITS clocks.
- ADDR_BITS, 4: register address width; must cover address NUM_LEDS+2+ceil(NUM_LEDS/4).
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- sleep  input  1  global sleep request; ORed with MODE.sleep.
- addr  input  ADDR_BITS  register address.
- w_en  input  1  write strobe, one cycle per write.
- r_en  input  1  read strobe, one cycle per read.
- wdata  input  DATA_BITS  write data.
- rdata  output  DATA_BITS  registered read data; reset 0.
- rvalid  output  1  pulses high one cycle with rdata; reset 0.
- led_out  output  NUM_LEDS  LED drive, active high before inversion; reset all 0.

## Operation
- Register map and reset values:
  - 0: MODE, reset 0x00. Bitfields: auto_increment[7:5] (stored, no effect), sleep[4], dim_blink[3], invert[2], output_change[1], reserved[0].
  - 1..NUM_LEDS: PWMn, reset 0x00.
  - NUM_LEDS+1: GRPPWM, reset 0xFF.
  - NUM_LEDS+2: GRPFREQ, reset 0x00.
  - NUM_LEDS+3 upward: LEDOUTk, reset 0x00. Each holds 2-bit modes for LEDs 4k..4k+3, LED 4k in bits [1:0]. Bits for nonexistent LEDs read 0.
- Mode encoding: 0 OFF, 1 ON, 2 INDIVIDUAL, 3 GROUP.
- Write to an unmapped address is ignored. Read of an unmapped address returns 0.
- pwm_cnt: DATA_BITS-bit counter, +1 per clock while awake, wraps from max to 0.
- blink_cnt: DATA_BITS-bit counter, +1 on each pwm_cnt wrap, wraps from GRPFREQ to 0.
- Group gate:
  - dim_blink=0: always 1.
  - dim_blink=1: 1 when blink_cnt·2^DATA_BITS < (GRPFREQ+1)·GRPPWM. Use 2·DATA_BITS+1-bit unsigned compare; no truncation.
- Per-LED raw output by mode:
  - OFF: 0.
  - ON: 1.
  - INDIVIDUAL: pwm_cnt < PWMn.
  - GROUP with dim_blink=0: pwm_cnt < (PWMn·GRPPWM)>>DATA_BITS.
  - GROUP with dim_blink=1: (pwm_cnt < PWMn) AND group gate.
- led_out = raw XOR MODE.invert, registered.
- Asleep (sleep input or MODE.sleep): pwm_cnt and blink_cnt are held at 0, led_out = MODE.invert for every bit. Register reads and writes still work.
- LEDOUT apply timing:
  - output_change=0: LEDOUT writes take effect on the next pwm_cnt wrap.
  - output_change=1: LEDOUT writes take effect the cycle after the write.
- Any register write at which GRPFREQ is lowered below the current blink_cnt resets blink_cnt to 0 on the next wrap.

## Timing
- Write: the register updates on the clk edge where w_en=1.
- Read: rdata and rvalid assert on the edge after r_en.
- Simultaneous w_en and r_en: both execute. A read of the same address returns the pre-write value.
- PWM duty: 0 gives constant 0. 2^DATA_BITS-1 gives high for 255 of 256 cycles.
- led_out lags the pwm_cnt value it is computed from by one cycle.
- Waking from sleep: pwm_cnt starts at 0 on the first awake cycle.
- Reset mid-period: all counters, registers and outputs return to their reset values immediately (asynchronous). Counting restarts on the first clock after deassertion.

## Configuration
- LED_PWM_SHADOW_EN defined:
  - Writes to PWMn, GRPPWM and GRPFREQ land in shadow registers.
  - Active copies load on the pwm_cnt wrap, so there is no mid-period glitch.
  - Reads return the shadow value.
- LED_PWM_SHADOW_EN undefined: those writes drive the active value from the next cycle.

## Test plan
- Reset defaults: assert reset, then release. Expect led_out=0 and rvalid=0; reading GRPPWM returns 0xFF one cycle later with rvalid=1.
- Individual PWM: write PWM0=0x40 and LEDOUT0=0x02 (output_change=1). Expect led_out[0] high for exactly 64 of every 256 cycles.
- Group dim: write PWM1=0x80, GRPPWM=0x80 and LED1 mode GROUP. Expect led_out[1] high for 64 of every 256 cycles.
- Blink: write dim_blink=1, GRPFREQ=3, GRPPWM=0x80 and PWM2=0xFF. Expect led_out[2] active for 2 PWM periods, then off for 2, repeating.
- Sleep and invert: with MODE.invert=1, drive sleep high mid-period. Expect all led_out=1 next cycle and counters at 0. On release, the PWM restarts from pwm_cnt=0.
- Shadow (macro on): write PWM0 mid-period. Expect the old duty to persist until the wrap and the new duty from the next period.
